// File: rtl/kb_boot_hotkey.sv
// Ctrl+Alt+Backspace hold detector: emits a stretched kb_boot_core pulse after a programmable hold.
// Define KB_BOOT_RIGHT_MODS_EN to also accept right Ctrl (E0 14) and right Alt (E0 11).
module kb_boot_hotkey #(
  parameter logic [23:0] HOLD_CYCLES  = 24'd14_000_000,
  parameter logic [7:0]  PULSE_CYCLES = 8'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_valid,
  input  logic [7:0] kb_scancode,
  input  logic       kb_extended,
  input  logic       kb_released,
  output logic       kb_boot_core,
  output logic [2:0] keys_held,
  output logic       armed
);

  localparam logic [7:0] CODE_CTRL = 8'h14;
  localparam logic [7:0] CODE_ALT  = 8'h11;
  localparam logic [7:0] CODE_BKSP = 8'h66;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_FIRE,
    S_WAIT_RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_hold_cnt;
  logic [23:0] w_hold_cnt_nxt;
  logic [7:0]  r_pulse_cnt;
  logic [7:0]  w_pulse_cnt_nxt;
  logic        r_boot;

  logic        r_ctrl_l;
  logic        r_alt_l;
  logic        r_bksp;
  logic        w_make;
  logic        w_ctrl;
  logic        w_alt;
  logic        w_combo;
  logic        w_all_clear;

  assign w_make = ~kb_released;

  // Left-hand / non-extended key flags; breaks of unheld keys simply rewrite a zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_l <= 1'b0;
      r_alt_l  <= 1'b0;
      r_bksp   <= 1'b0;
    end else if (kb_valid && !kb_extended) begin
      case (kb_scancode)
        CODE_CTRL: r_ctrl_l <= w_make;
        CODE_ALT:  r_alt_l  <= w_make;
        CODE_BKSP: r_bksp   <= w_make;
        default: ;
      endcase
    end
  end

`ifdef KB_BOOT_RIGHT_MODS_EN
  logic r_ctrl_r;
  logic r_alt_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_r <= 1'b0;
      r_alt_r  <= 1'b0;
    end else if (kb_valid && kb_extended) begin
      case (kb_scancode)
        CODE_CTRL: r_ctrl_r <= w_make;
        CODE_ALT:  r_alt_r  <= w_make;
        default: ;
      endcase
    end
  end

  assign w_ctrl      = r_ctrl_l | r_ctrl_r;
  assign w_alt       = r_alt_l | r_alt_r;
  assign w_all_clear = ~(r_ctrl_l | r_ctrl_r | r_alt_l | r_alt_r | r_bksp);
`else
  assign w_ctrl      = r_ctrl_l;
  assign w_alt       = r_alt_l;
  assign w_all_clear = ~(r_ctrl_l | r_alt_l | r_bksp);
`endif

  assign w_combo = w_ctrl & w_alt & r_bksp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= 24'd0;
      r_pulse_cnt <= 8'd0;
      r_boot      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_boot      <= (w_state_nxt == S_FIRE);
    end
  end

  // A combo drop wins over the terminal count in the same cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_pulse_cnt_nxt = r_pulse_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_combo) begin
          w_state_nxt    = S_HOLD;
          w_hold_cnt_nxt = 24'd0;
        end
      end
      S_HOLD: begin
        if (!w_combo) begin
          w_state_nxt    = S_IDLE;
          w_hold_cnt_nxt = 24'd0;
        end else if (r_hold_cnt == HOLD_CYCLES - 24'd1) begin
          w_state_nxt     = S_FIRE;
          w_pulse_cnt_nxt = 8'd0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 24'd1;
        end
      end
      S_FIRE: begin
        if (r_pulse_cnt == PULSE_CYCLES - 8'd1) begin
          w_state_nxt = S_WAIT_RELEASE;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + 8'd1;
        end
      end
      S_WAIT_RELEASE: begin
        if (w_all_clear) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign kb_boot_core = r_boot;
  assign keys_held    = {r_bksp, w_alt, w_ctrl};
  assign armed        = (r_state == S_IDLE) || (r_state == S_HOLD);

endmodule

// File: tb/tb_kb_boot_hotkey.sv
// Scoreboard bench for kb_boot_hotkey: a time-based key model predicts pulse start edges and per-cycle outputs.
module tb_kb_boot_hotkey;

  localparam int H = 100;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kb_valid = 1'b0;
  logic [7:0] kb_scancode = 8'h00;
  logic       kb_extended = 1'b0;
  logic       kb_released = 1'b0;
  logic       kb_boot_core;
  logic [2:0] keys_held;
  logic       armed;

  always #5 clk = ~clk;

  kb_boot_hotkey #(
    .HOLD_CYCLES (24'd100),
    .PULSE_CYCLES(8'd16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .kb_valid    (kb_valid),
    .kb_scancode (kb_scancode),
    .kb_extended (kb_extended),
    .kb_released (kb_released),
    .kb_boot_core(kb_boot_core),
    .keys_held   (keys_held),
    .armed       (armed)
  );

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  bit chk_en = 1'b0;
  bit done = 1'b0;
  bit final_checked = 1'b0;
  bit prev_boot = 1'b0;

  // Model: every key is remembered by {extended, code}; the outputs are derived from that set.
  bit held [512];
  int run = 0;     // consecutive armed edges seen with the combo held
  int rem = 0;     // pulse edges still to come
  int phase = 0;   // 0 armed, 1 pulsing, 2 locked out until release
  bit m_boot = 1'b0;

  function automatic logic [2:0] model_keys();
    logic c, a;
    c = held[9'h014];
    a = held[9'h011];
`ifdef KB_BOOT_RIGHT_MODS_EN
    c = c | held[9'h114];
    a = a | held[9'h111];
`endif
    return {held[9'h066], a, c};
  endfunction

  function automatic bit model_all_clear();
    bit any;
    any = held[9'h014] | held[9'h011] | held[9'h066];
`ifdef KB_BOOT_RIGHT_MODS_EN
    any = any | held[9'h114] | held[9'h111];
`endif
    return !any;
  endfunction

  always @(posedge clk) begin
    logic [2:0] pre;
    cyc = cyc + 1;
    if (rst) begin
      foreach (held[i]) held[i] = 1'b0;
      run = 0;
      rem = 0;
      phase = 0;
      m_boot = 1'b0;
    end else begin
      pre = model_keys();
      case (phase)
        0: begin
          if (pre == 3'b111) begin
            run = run + 1;
            if (run == H + 1) begin
              phase = 1;
              rem = P - 1;
              m_boot = 1'b1;
              run = 0;
              exp_q.push_back(cyc);
            end
          end else begin
            run = 0;
          end
        end
        1: begin
          if (rem == 0) begin
            phase = 2;
            m_boot = 1'b0;
          end else begin
            rem = rem - 1;
          end
        end
        default: begin
          if (model_all_clear()) begin
            phase = 0;
            run = 0;
          end
        end
      endcase
      if (kb_valid) held[{kb_extended, kb_scancode}] = !kb_released;
    end
  end

  always @(negedge clk) begin
    int e;
    logic [2:0] mk;
    if (chk_en) begin
      mk = model_keys();
      vectors = vectors + 1;
      if (kb_boot_core !== m_boot || armed !== (phase == 0) || keys_held !== mk) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs @edge %0d: got boot=%b armed=%b keys=%b, want boot=%b armed=%b keys=%b",
                 cyc, kb_boot_core, armed, keys_held, m_boot, (phase == 0), mk);
      end
      if (kb_boot_core === 1'b1 && !prev_boot) begin
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL pulse_start: got rise at edge %0d, want no pulse", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != cyc) begin
            miscompares = miscompares + 1;
            $display("FAIL pulse_start: got rise at edge %0d, want edge %0d", cyc, e);
          end
        end
      end
      prev_boot = (kb_boot_core === 1'b1);
      if (done && !final_checked) begin
        final_checked = 1'b1;
        vectors = vectors + 1;
        if (exp_q.size() != 0) begin
          miscompares = miscompares + 1;
          $display("FAIL pulse_missing: got %0d pulses outstanding, want 0 (next expected edge %0d)",
                   exp_q.size(), exp_q[0]);
        end
      end
    end
  end

  task automatic key(input logic [7:0] code, input logic ext, input logic rel);
    kb_valid    = 1'b1;
    kb_scancode = code;
    kb_extended = ext;
    kb_released = rel;
    @(negedge clk);
    kb_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_combo();
    key(8'h14, 1'b0, 1'b0);
    idle(9);
    key(8'h11, 1'b0, 1'b0);
    idle(9);
    key(8'h66, 1'b0, 1'b0);
  endtask

  task automatic release_all();
    key(8'h14, 1'b0, 1'b1);
    key(8'h11, 1'b0, 1'b1);
    key(8'h66, 1'b0, 1'b1);
    key(8'h14, 1'b1, 1'b1);
    key(8'h11, 1'b1, 1'b1);
    idle(5);
  endtask

  logic [8:0] tbl [0:6];

  initial begin
    tbl[0] = 9'h014; tbl[1] = 9'h011; tbl[2] = 9'h066; tbl[3] = 9'h114;
    tbl[4] = 9'h111; tbl[5] = 9'h01C; tbl[6] = 9'h166;

    idle(2);
    chk_en = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6);

    // Basic press and hold, then release
    press_combo();
    idle(200);
    release_all();
    idle(10);

    // Backspace dropped mid-hold, then re-pressed for a full hold
    press_combo();
    idle(50);
    key(8'h66, 1'b0, 1'b1);
    idle(20);
    key(8'h66, 1'b0, 1'b0);
    idle(150);
    release_all();

    // Long hold gives one pulse; alt alone released does not re-arm
    press_combo();
    idle(1000);
    key(8'h11, 1'b0, 1'b1);
    idle(30);
    key(8'h14, 1'b0, 1'b1);
    idle(3);
    key(8'h66, 1'b0, 1'b1);
    idle(10);

    // Typematic backspace repeats during the hold
    press_combo();
    for (int i = 0; i < 10; i++) begin
      idle(19);
      key(8'h66, 1'b0, 1'b0);
    end
    release_all();

    // Reset five cycles into the pulse
    press_combo();
    idle(105);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(300);
    press_combo();
    idle(150);
    release_all();

    // Right ctrl stands in for left ctrl only when the option is built in
    key(8'h14, 1'b1, 1'b0);
    idle(3);
    key(8'h11, 1'b0, 1'b0);
    idle(3);
    key(8'h66, 1'b0, 1'b0);
    idle(150);
    release_all();

    // Extended break of ctrl must not touch the left-ctrl flag
    key(8'h14, 1'b0, 1'b0);
    idle(2);
    key(8'h14, 1'b1, 1'b1);
    idle(2);
    release_all();

    // Random key traffic with occasional full-combo presses
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        press_combo();
      end else begin
        logic [8:0] k;
        k = tbl[$urandom_range(0, 6)];
        key(k[7:0], k[8], 1'($urandom_range(0, 1)));
      end
      idle($urandom_range(0, 150));
    end
    release_all();
    idle(40);

    done = 1'b1;
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kb_boot_hotkey.md
# kb_boot_hotkey

Upstream keyboard stage of the core-switch path: watches decoded PS/2 scancode events for the Ctrl+Alt+Backspace combination. When the combination is held continuously for a programmable time, it emits a stretched pulse on `kb_boot_core`, which feeds the multiboot block's keyboard reboot input. A lockout stops a second pulse until all three keys are released. The pulse is stretched so the ICAP-clock synchroniser (clk_icap ≤ 20 MHz) always detects it.

## Interface
- `HOLD_CYCLES`, default 24'd14_000_000: combo must be held this many `clk` cycles (0.5 s at 28 MHz); legal range 1..2^24-1.
- `PULSE_CYCLES`, default 8'd16: width of the `kb_boot_core` pulse in `clk` cycles; must be ≥ 4 and cover ≥ 3 clk_icap periods.
- `clk`, in, 1: system clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `kb_valid`, in, 1: one-cycle strobe; one complete key event is present on `kb_scancode`, `kb_extended` and `kb_released`.
- `kb_scancode`, in, 8: set-2 make code of the event.
- `kb_extended`, in, 1: event was E0-prefixed.
- `kb_released`, in, 1: event is a break (F0), not a make.
- `kb_boot_core`, out, 1: reboot request pulse to the multiboot block.
- `keys_held`, out, 3: {backspace, alt, ctrl} held flags, for debug/OSD.
- `armed`, out, 1: high in IDLE and HOLD, meaning a new trigger is possible.

## Operation
- Key tracking, updated only on `kb_valid`:
  - ctrl = code 0x14 non-extended.
  - alt = 0x11 non-extended.
  - backspace = 0x66 non-extended.
  - A make sets the flag; a break clears it.
  - Repeated makes (typematic) leave a set flag set.
  - A break for a key that is not held has no effect.
  - Every other code is ignored.
- `combo` = all three flags set.
- States: IDLE, HOLD, FIRE, WAIT_RELEASE.
- IDLE:
  - combo → HOLD, hold counter cleared to 0.
  - Otherwise stay in IDLE.
- HOLD:
  - Counter increments each cycle.
  - If combo drops, go to IDLE and clear the counter.
  - If counter == HOLD_CYCLES-1 and combo is still true, go to FIRE and clear the pulse counter.
  - A combo drop takes precedence over a terminal count in the same cycle.
- FIRE:
  - `kb_boot_core` is high.
  - Pulse counter increments.
  - At PULSE_CYCLES-1 go to WAIT_RELEASE.
  - Key events are still tracked but cannot shorten the pulse.
- WAIT_RELEASE: go to IDLE only when all three flags are clear. Pressing and releasing other keys has no effect.
- `kb_boot_core` is driven from a register, so it is glitch-free.
- Outputs after reset: `kb_boot_core`=0, `keys_held`=3'b000, `armed`=1, state IDLE, both counters 0.
- Reset mid-HOLD or mid-FIRE aborts at once; the pulse is truncated and the next cycle shows reset values.

## Timing
- Edge E captures the completing make; `keys_held` shows 3'b111 after E.
- State becomes HOLD at E+1.
- `kb_boot_core` rises at edge E+1+HOLD_CYCLES.
- `kb_boot_core` stays high for exactly PULSE_CYCLES cycles.
- `armed` falls on the same edge that `kb_boot_core` rises, and rises again on the cycle after the last flag clears in WAIT_RELEASE.
- A break captured at edge B during HOLD returns the state to IDLE at B+1; no pulse is produced.
- `keys_held` updates one cycle after `kb_valid`.
- No input is registered twice, so latency is exactly as stated above.

## Configuration
- `KB_BOOT_RIGHT_MODS_EN` defined:
  - Right Ctrl (E0 14) and right Alt (E0 11) are also tracked, as separate internal flags.
  - ctrl held = left OR right; alt held = left OR right.
  - WAIT_RELEASE requires all four modifier flags and backspace clear.
- Not defined: E0-prefixed events are fully ignored. E0 14 never sets or clears the left-ctrl flag.

## Test plan
All tests use HOLD_CYCLES=100 and PULSE_CYCLES=16.
- Press ctrl, alt, backspace in order (makes at edges 10, 20, 30) and hold → `kb_boot_core` high from edge 131 to 146 inclusive (16 cycles); `armed`=0 from 131.
- Combo held, then backspace released after 50 cycles in HOLD → no pulse; `armed` stays 1; re-press with a full hold → pulse exactly 100+1 cycles after the re-press.
- After a pulse, keep the combo held for 1000 cycles → exactly one pulse. Release alt only → no re-arm. Release all → `armed`=1 one cycle after the last break.
- Typematic: repeat backspace make every 20 cycles during HOLD → counter not reset; pulse timing unchanged.
- Assert `rst` 5 cycles into FIRE → `kb_boot_core`=0 and `keys_held`=000 on the next cycle; no further pulse until the combo is pressed again.
- E0 14 + alt + backspace:
  - macro off → no pulse;
  - macro on → pulse at 101 cycles after the completing make.
